valu_result_collector: RTL and testbench

- Downstream neighbour of the four-lane vector ALU control FSM.
- Assembles the two per-phase lane results (phase 1, then phase 2) into one 8-element result vector, latched with its destination register address.
- Presents the vector to the vector register file through a valid/ready write-back handshake.
- Drives `busy` back to the issue stage so that no new ALU operation starts while a result is still undelivered.

---
 rtl/valu_pkg.sv | 33 +++
 rtl/valu_result_collector.sv | 146 ++++++++++++++
 tb/tb_valu_result_collector.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/valu_pkg.sv
// Shared definitions for the four-lane vector ALU slice: issue, control and
// result collector all import this package.
//   - default geometry (lanes, element width, phases, register address width)
//   - ALU op encodings
//   - result collector state encoding
package valu_pkg;

  localparam int unsigned VALU_LANES  = 4;
  localparam int unsigned VALU_ELEM_W = 8;
  localparam int unsigned VALU_PHASES = 2;
  localparam int unsigned VALU_ADDR_W = 4;
  localparam int unsigned VALU_OP_W   = 3;

  // ALU op encodings shared by issue and the ALU control FSM
  typedef enum logic [VALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  // Result collector states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WB_PEND = 2'd2
  } coll_state_e;

endpackage : valu_pkg

// File: rtl/valu_result_collector.sv
// Result collector for the four-lane vector ALU.
// Gathers the phase-1 and phase-2 lane results into one vector, latches the
// destination register, and offers the vector to the register file through a
// valid/ready write-back handshake. Flags protocol violations in a sticky bit.
// Ports:
//   clk, reset        clock (posedge), asynchronous active-high reset
//   alu_start         issue strobe; dst_addr sampled with an accepted start
//   out_en1/out_en2   phase-1 / phase-2 lane results valid on lane_result
//   alu_rdy           ALU op complete
//   lane_result       LANES lane outputs, lane i at [i*ELEM_W +: ELEM_W]
//   wb_valid/wb_ready write-back handshake
//   wb_addr, wb_data  latched destination and assembled vector
//   busy              collector occupied (combinational release on accept)
//   overrun           sticky protocol error
module valu_result_collector
  import valu_pkg::*;
#(
  parameter int unsigned LANES  = VALU_LANES,
  parameter int unsigned ELEM_W = VALU_ELEM_W,
  parameter int unsigned PHASES = VALU_PHASES,
  parameter int unsigned ADDR_W = VALU_ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alu_start,
  input  logic [ADDR_W-1:0]                dst_addr,
  input  logic                             out_en1,
  input  logic                             out_en2,
  input  logic                             alu_rdy,
  input  logic [LANES*ELEM_W-1:0]          lane_result,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ADDR_W-1:0]                wb_addr,
  output logic [LANES*PHASES*ELEM_W-1:0]   wb_data,
  output logic                             busy,
  output logic                             overrun
);

  localparam int unsigned VEC_W = LANES * PHASES * ELEM_W;

  coll_state_e       state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [VEC_W-1:0]  wb_data_q, wb_data_d;
  logic              overrun_q, overrun_d;
  logic              got1_q, got1_d;
  logic              got2_q, got2_d;
  logic              cap1, cap2;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      overrun_q  <= 1'b0;
      got1_q     <= 1'b0;
      got2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      overrun_q  <= overrun_d;
      got1_q     <= got1_d;
      got2_q     <= got2_d;
    end
  end

  // Next-state, capture enables and error detection
  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    overrun_d  = overrun_q;
    got1_d     = got1_q;
    got2_d     = got2_q;
    cap1       = 1'b0;
    cap2       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (out_en1 || out_en2 || alu_rdy) overrun_d = 1'b1;
        if (alu_start) begin
          wb_addr_d = dst_addr;
          got1_d    = 1'b0;
          got2_d    = 1'b0;
          state_d   = COLLECT;
        end
      end

      COLLECT: begin
        cap1   = out_en1;
        cap2   = out_en2;
        got1_d = got1_q | out_en1;
        got2_d = got2_q | out_en2;
        if (alu_start) overrun_d = 1'b1;
        if (alu_rdy) begin
          // A capture in the same cycle as alu_rdy still counts for the op
          if (!(got1_d && got2_d)) overrun_d = 1'b1;
          wb_valid_d = 1'b1;
          state_d    = WB_PEND;
        end
      end

      WB_PEND: begin
        if (out_en1 || out_en2) overrun_d = 1'b1;
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          if (alu_start) begin
            // Legal back-to-back issue in the accepting cycle
            wb_addr_d = dst_addr;
            got1_d    = 1'b0;
            got2_d    = 1'b0;
            state_d   = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (alu_start) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Per-lane element capture: phase 1 fills elements 0..LANES-1,
  // phase 2 fills LANES..2*LANES-1; uncaptured elements hold.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign wb_data_d[i*ELEM_W +: ELEM_W] =
      cap1 ? lane_result[i*ELEM_W +: ELEM_W] : wb_data_q[i*ELEM_W +: ELEM_W];
    assign wb_data_d[(LANES+i)*ELEM_W +: ELEM_W] =
      cap2 ? lane_result[i*ELEM_W +: ELEM_W] : wb_data_q[(LANES+i)*ELEM_W +: ELEM_W];
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign overrun  = overrun_q;

  // Released combinationally in the accepting cycle so issue can start at once
  assign busy = (state_q != IDLE) && !((state_q == WB_PEND) && wb_ready);

endmodule : valu_result_collector

// File: tb/tb_valu_result_collector.sv
// Directed self-checking bench for valu_result_collector.
// Inputs change on negedge; registered outputs are checked 1 time unit after
// posedge, busy (combinational) is checked right after the input change.
module tb_valu_result_collector;

  localparam int unsigned LANES  = 4;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned PHASES = 2;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned VEC_W  = LANES * PHASES * ELEM_W;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    alu_start = 1'b0;
  logic [ADDR_W-1:0]       dst_addr = '0;
  logic                    out_en1 = 1'b0;
  logic                    out_en2 = 1'b0;
  logic                    alu_rdy = 1'b0;
  logic [LANES*ELEM_W-1:0] lane_result = '0;
  logic                    wb_ready = 1'b0;
  logic                    wb_valid;
  logic [ADDR_W-1:0]       wb_addr;
  logic [VEC_W-1:0]        wb_data;
  logic                    busy;
  logic                    overrun;

  int n_checks = 0;
  int n_fail   = 0;

  valu_result_collector #(
    .LANES(LANES), .ELEM_W(ELEM_W), .PHASES(PHASES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .alu_start(alu_start), .dst_addr(dst_addr),
    .out_en1(out_en1), .out_en2(out_en2), .alu_rdy(alu_rdy),
    .lane_result(lane_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Apply one cycle's inputs on the falling edge
  task automatic drive(input logic st, input logic [ADDR_W-1:0] a,
                       input logic e1, input logic e2, input logic rdy,
                       input logic rd, input logic [LANES*ELEM_W-1:0] lr);
    @(negedge clk);
    alu_start = st; dst_addr = a; out_en1 = e1; out_en2 = e2;
    alu_rdy = rdy; wb_ready = rd; lane_result = lr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    alu_start = 1'b0; out_en1 = 1'b0; out_en2 = 1'b0; alu_rdy = 1'b0;
    wb_ready = 1'b0; dst_addr = '0; lane_result = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full op start/phase1/phase2/rdy; leaves wb_valid just raised
  task automatic run_op(input logic [ADDR_W-1:0] a,
                        input logic [31:0] l1, input logic [31:0] l2);
    drive(1, a, 0, 0, 0, 0, '0); tick();
    drive(0, '0, 1, 0, 0, 0, l1); tick();
    drive(0, '0, 0, 1, 0, 0, l2); tick();
    drive(0, '0, 0, 0, 1, 0, '0); tick();
  endtask

  task automatic deliver();
    drive(0, '0, 0, 0, 0, 1, '0); tick();
    drive(0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b0;
    #1;
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (wb_addr !== 4'h0) begin n_fail++; $display("FAIL rst_wb_addr got %h want 0", wb_addr); end
    // Reset in the middle of a collection
    drive(1, 4'h7, 0, 0, 0, 0, '0); tick();
    drive(0, '0, 1, 0, 0, 0, 32'hAABBCCDD); tick();
    n_checks++; if (wb_data !== 64'h00000000AABBCCDD) begin n_fail++; $display("FAIL mid_capture got %h want 00000000aabbccdd", wb_data); end
    @(negedge clk); out_en1 = 1'b0; reset = 1'b1;
    #1;
    n_checks++; if (wb_data !== 64'h0) begin n_fail++; $display("FAIL rst_mid_wb_data got %h want 0", wb_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb_valid got %b want 0", wb_valid); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_nominal();
    drive(1, 4'h3, 0, 0, 0, 0, '0); tick();
    drive(0, '0, 1, 0, 0, 0, 32'h04030201); tick();
    drive(0, '0, 0, 1, 0, 0, 32'h08070605); tick();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL nom_early_valid got %b want 0", wb_valid); end
    drive(0, '0, 0, 0, 1, 0, '0); tick();
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid got %b want 1", wb_valid); end
    n_checks++; if (wb_addr !== 4'h3) begin n_fail++; $display("FAIL nom_addr got %h want 3", wb_addr); end
    n_checks++; if (wb_data !== 64'h0807060504030201) begin n_fail++; $display("FAIL nom_data got %h want 0807060504030201", wb_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy_pend got %b want 1", busy); end
    drive(0, '0, 0, 0, 0, 1, '0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_accept got %b want 0", busy); end
    tick();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL nom_valid_drop got %b want 0", wb_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL nom_overrun got %b want 0", overrun); end
    drive(0, '0, 0, 0, 0, 0, '0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    run_op(4'h5, 32'h44332211, 32'h88776655);
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0, 0, 0, 0, '0); tick();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, wb_valid); end
      n_checks++; if (wb_addr !== 4'h5) begin n_fail++; $display("FAIL bp_addr[%0d] got %h want 5", i, wb_addr); end
      n_checks++; if (wb_data !== 64'h8877665544332211) begin n_fail++; $display("FAIL bp_data[%0d] got %h want 8877665544332211", i, wb_data); end
    end
    deliver();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done_valid got %b want 0", wb_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_done_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    run_op(4'h2, 32'h0D0C0B0A, 32'h1D1C1B1A);
    n_checks++; if (wb_data !== 64'h1D1C1B1A0D0C0B0A) begin n_fail++; $display("FAIL b2b_first_data got %h want 1d1c1b1a0d0c0b0a", wb_data); end
    drive(1, 4'h9, 0, 0, 0, 1, '0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_accept got %b want 0", busy); end
    tick();
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b want 0", wb_valid); end
    n_checks++; if (wb_addr !== 4'h9) begin n_fail++; $display("FAIL b2b_addr got %h want 9", wb_addr); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    drive(0, '0, 1, 0, 0, 0, 32'h2D2C2B2A);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_collect got %b want 1", busy); end
    tick();
    drive(0, '0, 0, 1, 0, 0, 32'h3D3C3B3A); tick();
    drive(0, '0, 0, 0, 1, 0, '0); tick();
    n_checks++; if (wb_data !== 64'h3D3C3B3A2D2C2B2A) begin n_fail++; $display("FAIL b2b_second_data got %h want 3d3c3b3a2d2c2b2a", wb_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_second_overrun got %b want 0", overrun); end
    deliver();
  endtask

  task automatic test_start_in_collect();
    do_reset();
    drive(1, 4'h6, 0, 0, 0, 0, '0); tick();
    drive(1, 4'hA, 0, 0, 0, 0, '0); tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL sic_overrun got %b want 1", overrun); end
    n_checks++; if (wb_addr !== 4'h6) begin n_fail++; $display("FAIL sic_addr got %h want 6", wb_addr); end
  endtask

  task automatic test_missing_phase2();
    do_reset();
    run_op(4'h1, 32'h04030201, 32'h08070605);
    deliver();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mp2_pre_overrun got %b want 0", overrun); end
    drive(1, 4'hC, 0, 0, 0, 0, '0); tick();
    drive(0, '0, 1, 0, 0, 0, 32'h14131211); tick();
    drive(0, '0, 0, 0, 1, 0, '0); tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL mp2_overrun got %b want 1", overrun); end
    n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL mp2_valid got %b want 1", wb_valid); end
    n_checks++; if (wb_data !== 64'h0807060514131211) begin n_fail++; $display("FAIL mp2_data got %h want 0807060514131211", wb_data); end
    deliver();
  endtask

  task automatic test_stray_idle();
    do_reset();
    run_op(4'h4, 32'h24232221, 32'h28272625);
    deliver();
    drive(0, '0, 1, 0, 0, 0, 32'hFFFFFFFF); tick();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL stray_overrun got %b want 1", overrun); end
    n_checks++; if (wb_data !== 64'h2827262524232221) begin n_fail++; $display("FAIL stray_data got %h want 2827262524232221", wb_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_busy got %b want 0", busy); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stray_valid got %b want 0", wb_valid); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_back_to_back();
    test_start_in_collect();
    test_missing_phase2();
    test_stray_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_valu_result_collector
